// File: rtl/phy_link_supervisor.sv
// Per-lane PHY link supervisor: lock timeout / loss detection, round-robin RX reset arbitration, sticky fault.
// Optional: define PHY_SUP_RELINK_CNT_EN to add per-lane 16-bit relink counters on output relink_cnt.
module phy_link_supervisor #(
  parameter int NUM_CH       = 4,
  parameter int LOCK_TIMEOUT = 1000000,
  parameter int LOSS_FILTER  = 64,
  parameter int RST_CYCLES   = 16,
  parameter int MAX_RETRY    = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pll_locked,
  input  logic [NUM_CH-1:0]         rx_ready,
  input  logic [NUM_CH-1:0]         block_lock,
  input  logic [NUM_CH-1:0]         clear_fault,
  output logic [NUM_CH-1:0]         rx_reset_req,
  output logic [NUM_CH-1:0]         link_up,
  output logic [NUM_CH-1:0]         fault,
  output logic [$clog2(NUM_CH)-1:0] grant_id,
  output logic                      grant_vld
`ifdef PHY_SUP_RELINK_CNT_EN
  ,
  output logic [NUM_CH*16-1:0]      relink_cnt
`endif
);
  localparam int IDW    = $clog2(NUM_CH);
  localparam int TMR_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int LOSS_W = $clog2(LOSS_FILTER + 1);
  localparam int RCNT_W = $clog2(RST_CYCLES + 1);
  localparam int RTY_W  = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {S_WAIT_LOCK, S_UP, S_REQ, S_RST, S_FAULT} state_t;

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [TMR_W-1:0]  timer_q [NUM_CH];
  logic [TMR_W-1:0]  timer_d [NUM_CH];
  logic [LOSS_W-1:0] loss_q  [NUM_CH];
  logic [LOSS_W-1:0] loss_d  [NUM_CH];
  logic [RCNT_W-1:0] rcnt_q  [NUM_CH];
  logic [RCNT_W-1:0] rcnt_d  [NUM_CH];
  logic [RTY_W-1:0]  retry_q [NUM_CH];
  logic [RTY_W-1:0]  retry_d [NUM_CH];
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] release_v;
  logic              grant_vld_q, grant_vld_d;
  logic [IDW-1:0]    grant_id_q, grant_id_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    sel, cand;
  logic              found;
  int                idx;

  always_comb begin
    release_v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      loss_d[i]  = loss_q[i];
      rcnt_d[i]  = rcnt_q[i];
      retry_d[i] = retry_q[i];
      // Losing the TX PLL parks every healthy lane in lock-wait with frozen timers.
      if (!pll_locked && state_q[i] != S_FAULT) begin
        state_d[i] = S_WAIT_LOCK;
        timer_d[i] = '0;
        loss_d[i]  = '0;
        rcnt_d[i]  = '0;
      end else begin
        case (state_q[i])
          S_WAIT_LOCK: begin
            timer_d[i] = timer_q[i] + 1'b1;
            if (rx_ready[i] && block_lock[i]) begin
              state_d[i] = S_UP;
              timer_d[i] = '0;
              loss_d[i]  = '0;
              retry_d[i] = '0;
            end else if (timer_q[i] == TMR_W'(LOCK_TIMEOUT - 1)) begin
              timer_d[i] = '0;
              state_d[i] = (retry_q[i] == RTY_W'(MAX_RETRY)) ? S_FAULT : S_REQ;
            end
          end
          S_UP: begin
            loss_d[i] = block_lock[i] ? '0 : loss_q[i] + 1'b1;
            if (!rx_ready[i] || (!block_lock[i] && loss_q[i] == LOSS_W'(LOSS_FILTER - 1))) begin
              state_d[i] = S_REQ;
              loss_d[i]  = '0;
            end
          end
          S_REQ: begin
            if (grant_vld_q && grant_id_q == IDW'(i)) begin
              state_d[i] = S_RST;
              rcnt_d[i]  = '0;
            end
          end
          S_RST: begin
            rcnt_d[i] = rcnt_q[i] + 1'b1;
            if (rcnt_q[i] == RCNT_W'(RST_CYCLES - 1)) begin
              state_d[i]   = S_WAIT_LOCK;
              timer_d[i]   = '0;
              rcnt_d[i]    = '0;
              release_v[i] = 1'b1;
              if (retry_q[i] != RTY_W'(MAX_RETRY)) retry_d[i] = retry_q[i] + 1'b1;
            end
          end
          S_FAULT: begin
            if (clear_fault[i]) begin
              state_d[i] = S_REQ;
              retry_d[i] = '0;
            end
          end
          default: state_d[i] = S_WAIT_LOCK;
        endcase
      end
    end
  end

  // Round-robin search starting at the pointer; a grant is only issued while idle.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = IDW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    grant_vld_d = grant_vld_q;
    grant_id_d  = grant_id_q;
    ptr_d       = ptr_q;
    if (!pll_locked) begin
      grant_vld_d = 1'b0;
    end else if (grant_vld_q) begin
      if (|release_v) grant_vld_d = 1'b0;
    end else if (found) begin
      grant_vld_d = 1'b1;
      grant_id_d  = sel;
      ptr_d       = (sel == IDW'(NUM_CH - 1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_WAIT_LOCK;
        timer_q[i] <= '0;
        loss_q[i]  <= '0;
        rcnt_q[i]  <= '0;
        retry_q[i] <= '0;
      end
      grant_vld_q <= 1'b0;
      grant_id_q  <= '0;
      ptr_q       <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        loss_q[i]  <= loss_d[i];
        rcnt_q[i]  <= rcnt_d[i];
        retry_q[i] <= retry_d[i];
      end
      grant_vld_q <= grant_vld_d;
      grant_id_q  <= grant_id_d;
      ptr_q       <= ptr_d;
    end
  end

  always_comb begin
    req          = '0;
    rx_reset_req = '0;
    link_up      = '0;
    fault        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req[i]          = (state_q[i] == S_REQ);
      rx_reset_req[i] = (state_q[i] == S_RST) && pll_locked;
      link_up[i]      = (state_q[i] == S_UP);
      fault[i]        = (state_q[i] == S_FAULT);
    end
  end

  assign grant_vld = grant_vld_q;
  assign grant_id  = grant_id_q;

`ifdef PHY_SUP_RELINK_CNT_EN
  logic [15:0] relink_q [NUM_CH];

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset || clear_fault[i]) begin
        relink_q[i] <= '0;
      end else if (state_q[i] == S_UP && state_d[i] == S_REQ && relink_q[i] != 16'hFFFF) begin
        relink_q[i] <= relink_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    relink_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) relink_cnt[i*16 +: 16] = relink_q[i];
  end
`endif

endmodule
